// File: rtl/lvds_rx_gearbox_align.sv
// N-to-M bit gearbox for multi-channel LVDS receive data. All channels slip together until
// channel 0 presents the forwarded clock pattern, then aligned OUT_W-bit words are presented.
module lvds_rx_gearbox_align #(
  parameter int unsigned       NUM_CH      = 5,
  parameter int unsigned       IN_W        = 8,
  parameter int unsigned       OUT_W       = 7,
  parameter logic [OUT_W-1:0]  CLK_PATTERN = 7'b110_0011,
  parameter int unsigned       LOCK_CNT    = 8,
  parameter int unsigned       LOSS_CNT    = 4,
  parameter int unsigned       SLIP_WAIT   = 6
) (
  input  logic                    i_px_clk,
  input  logic                    i_reset,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [NUM_CH*IN_W-1:0]  i_in_data,
  input  logic                    i_align_restart,
  output logic                    o_out_valid,
  output logic [NUM_CH*OUT_W-1:0] o_out_data,
  output logic                    o_px_ready,
  output logic                    o_align_fail,
  output logic [7:0]              o_slip_count,
  output logic [7:0]              o_lock_loss_count
);

  localparam int unsigned BUF_W  = 2 * (IN_W + OUT_W);
  localparam int unsigned FILL_W = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {StCheck, StSlip, StWait, StLocked} state_e;

  state_e                          r_state, w_state_d;
  logic                            r_run;
  logic [FILL_W-1:0]               r_fill, w_fill_d, w_rem;
  logic [NUM_CH-1:0][BUF_W-1:0]    r_buf, w_buf_d;
  logic [NUM_CH-1:0][OUT_W-1:0]    r_out_data, w_head;
  logic                            r_out_valid, r_px_ready;
  logic [7:0]                      r_match_cnt, w_match_d;
  logic [7:0]                      r_miss_cnt, w_miss_d;
  logic [7:0]                      r_wait_cnt, w_wait_d;
  logic [7:0]                      r_slip_cnt, w_slip_cnt_d;
  logic [7:0]                      r_loss_cnt, w_loss_d;
  logic                            r_align_fail, w_fail_d;
  logic                            w_emit, w_slip, w_accept, w_fit, w_match;

  // Consumption this cycle depends only on registered state, so in_ready does too.
  always_comb begin
    w_slip = (r_state == StSlip) && (r_fill != '0);
    w_emit = (r_state != StSlip) && (32'(r_fill) >= OUT_W);
    w_rem  = r_fill;
    if (w_emit) begin
      w_rem = r_fill - FILL_W'(OUT_W);
    end else if (w_slip) begin
      w_rem = r_fill - FILL_W'(1);
    end
    w_fit    = (32'(w_rem) + IN_W) <= BUF_W;
    w_accept = i_in_valid && o_in_ready;
    w_fill_d = w_accept ? (w_rem + FILL_W'(IN_W)) : w_rem;
  end

  assign o_in_ready = r_run && w_fit;

  // Bit 0 of each channel buffer is the oldest bit; bits at or above the fill are kept zero.
  always_comb begin
    w_buf_d = r_buf;
    w_head  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_head[c] = r_buf[c][OUT_W-1:0];
      if (w_emit) begin
        w_buf_d[c] = r_buf[c] >> OUT_W;
      end else if (w_slip) begin
        w_buf_d[c] = r_buf[c] >> 1;
      end
      if (w_accept) begin
        w_buf_d[c] = w_buf_d[c] | (BUF_W'(i_in_data[c*IN_W +: IN_W]) << w_rem);
      end
    end
  end

  assign w_match = (w_head[0] == CLK_PATTERN);

  always_comb begin
    w_state_d    = r_state;
    w_match_d    = r_match_cnt;
    w_miss_d     = r_miss_cnt;
    w_wait_d     = r_wait_cnt;
    w_slip_cnt_d = r_slip_cnt;
    w_loss_d     = r_loss_cnt;
    w_fail_d     = r_align_fail;
    unique case (r_state)
      StCheck: begin
        if (w_emit) begin
          if (w_match) begin
            w_match_d = r_match_cnt + 8'd1;
            if (32'(r_match_cnt) + 32'd1 >= LOCK_CNT) w_state_d = StLocked;
          end else begin
            w_match_d = '0;
            w_state_d = StSlip;
          end
        end
      end
      StSlip: begin
        if (w_slip) begin
          if (r_slip_cnt != 8'hff) w_slip_cnt_d = r_slip_cnt + 8'd1;
          w_wait_d  = '0;
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (w_emit) begin
          if (32'(r_wait_cnt) + 32'd1 >= SLIP_WAIT) begin
            w_wait_d  = '0;
            w_state_d = StCheck;
          end else begin
            w_wait_d = r_wait_cnt + 8'd1;
          end
        end
      end
      StLocked: begin
        if (w_emit) begin
          if (w_match) begin
            w_miss_d = '0;
          end else if (32'(r_miss_cnt) + 32'd1 >= LOSS_CNT) begin
            w_miss_d     = '0;
            w_match_d    = '0;
            w_slip_cnt_d = '0;
            if (r_loss_cnt != 8'hff) w_loss_d = r_loss_cnt + 8'd1;
            w_state_d    = StCheck;
          end else begin
            w_miss_d = r_miss_cnt + 8'd1;
          end
        end
      end
      default: w_state_d = StCheck;
    endcase
    if (32'(w_slip_cnt_d) >= 2 * OUT_W) w_fail_d = 1'b1;
    // Restart overrides whatever transition the FSM chose this cycle; buffered bits survive.
    if (i_align_restart) begin
      w_state_d    = StCheck;
      w_match_d    = '0;
      w_miss_d     = '0;
      w_wait_d     = '0;
      w_slip_cnt_d = '0;
      w_fail_d     = 1'b0;
    end
  end

  always_ff @(posedge i_px_clk or posedge i_reset) begin
    if (i_reset) begin
      r_run        <= 1'b0;
      r_fill       <= '0;
      r_buf        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_px_ready   <= 1'b0;
      r_state      <= StCheck;
      r_match_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_slip_cnt   <= '0;
      r_loss_cnt   <= '0;
      r_align_fail <= 1'b0;
    end else begin
      r_run        <= 1'b1;
      r_fill       <= w_fill_d;
      r_buf        <= w_buf_d;
      r_out_valid  <= w_emit;
      if (w_emit) r_out_data <= w_head;
      // Lags the state by one cycle so it rises after the locking word is on the output.
      r_px_ready   <= (r_state == StLocked) && !i_align_restart;
      r_state      <= w_state_d;
      r_match_cnt  <= w_match_d;
      r_miss_cnt   <= w_miss_d;
      r_wait_cnt   <= w_wait_d;
      r_slip_cnt   <= w_slip_cnt_d;
      r_loss_cnt   <= w_loss_d;
      r_align_fail <= w_fail_d;
    end
  end

  assign o_out_valid       = r_out_valid;
  assign o_out_data        = r_out_data;
  assign o_px_ready        = r_px_ready;
  assign o_align_fail      = r_align_fail;
  assign o_slip_count      = r_slip_cnt;
  assign o_lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_lvds_rx_gearbox_align.sv
// Bench for lvds_rx_gearbox_align: bit-queue reference model checked every cycle, plus
// directed phases with hand-derived expectations.
module tb_lvds_rx_gearbox_align;

  localparam int NUM_CH    = 2;
  localparam int IN_W      = 8;
  localparam int OUT_W     = 7;
  localparam int LOCK_CNT  = 8;
  localparam int LOSS_CNT  = 4;
  localparam int SLIP_WAIT = 6;
  localparam int BUF_W     = 2 * (IN_W + OUT_W);
  localparam logic [OUT_W-1:0] PAT = 7'b110_0011;

  localparam int MCheck  = 0;
  localparam int MSlip   = 1;
  localparam int MWait   = 2;
  localparam int MLocked = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     restart = 1'b0;
  logic [NUM_CH*IN_W-1:0]   in_data = '0;
  logic                     in_ready, out_valid, px_ready, align_fail;
  logic [NUM_CH*OUT_W-1:0]  out_data;
  logic [7:0]               slip_count, lock_loss_count;

  always #5 clk = ~clk;

  lvds_rx_gearbox_align #(
    .NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .CLK_PATTERN(PAT),
    .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .i_px_clk(clk),
    .i_reset(rst),
    .i_in_valid(in_valid),
    .o_in_ready(in_ready),
    .i_in_data(in_data),
    .i_align_restart(restart),
    .o_out_valid(out_valid),
    .o_out_data(out_data),
    .o_px_ready(px_ready),
    .o_align_fail(align_fail),
    .o_slip_count(slip_count),
    .o_lock_loss_count(lock_loss_count)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue entry per bit time, one bit per channel.
  logic [NUM_CH-1:0]        mq[$];
  int                       m_st, m_match, m_miss, m_wait, m_slip, m_loss, m_emitted;
  bit                       m_fail, m_px, m_run, m_ov;
  logic [NUM_CH*OUT_W-1:0]  m_od;

  // Stimulus state: k = words accepted since reset.
  int k, off, ch0_zero, cor_lo, cor_hi;

  function automatic int m_consume();
    if (m_st == MSlip) return (mq.size() >= 1) ? 1 : 0;
    return (mq.size() >= OUT_W) ? OUT_W : 0;
  endfunction

  function automatic bit m_ready();
    return m_run && (mq.size() - m_consume() + IN_W <= BUF_W);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_st = MCheck; m_match = 0; m_miss = 0; m_wait = 0; m_slip = 0; m_loss = 0;
    m_fail = 0; m_px = 0; m_run = 0; m_ov = 0; m_od = '0; k = 0;
  endtask

  task automatic model_step();
    bit emit, slip, acc, match;
    logic [NUM_CH-1:0] e;
    if (rst) begin
      model_reset();
      return;
    end
    slip = (m_st == MSlip) && (mq.size() >= 1);
    emit = (m_st != MSlip) && (mq.size() >= OUT_W);
    acc  = in_valid && m_ready();
    m_ov = emit;
    if (emit) begin
      for (int b = 0; b < OUT_W; b++) begin
        e = mq.pop_front();
        for (int c = 0; c < NUM_CH; c++) m_od[c*OUT_W+b] = e[c];
      end
      m_emitted++;
    end
    if (slip) void'(mq.pop_front());
    if (acc) begin
      for (int b = 0; b < IN_W; b++) begin
        for (int c = 0; c < NUM_CH; c++) e[c] = in_data[c*IN_W+b];
        mq.push_back(e);
      end
      k++;
    end
    match = (m_od[OUT_W-1:0] == PAT);
    m_px  = (m_st == MLocked) && !restart;
    if (restart) begin
      m_st = MCheck; m_match = 0; m_miss = 0; m_wait = 0; m_slip = 0; m_fail = 0;
    end else begin
      case (m_st)
        MCheck: if (emit) begin
          if (match) begin
            m_match++;
            if (m_match == LOCK_CNT) m_st = MLocked;
          end else begin
            m_match = 0;
            m_st = MSlip;
          end
        end
        MSlip: if (slip) begin
          if (m_slip < 255) m_slip++;
          if (m_slip == 2 * OUT_W) m_fail = 1;
          m_wait = 0;
          m_st = MWait;
        end
        MWait: if (emit) begin
          m_wait++;
          if (m_wait == SLIP_WAIT) m_st = MCheck;
        end
        default: if (emit) begin
          if (match) begin
            m_miss = 0;
          end else begin
            m_miss++;
            if (m_miss == LOSS_CNT) begin
              if (m_loss < 255) m_loss++;
              m_slip = 0; m_match = 0; m_miss = 0;
              m_st = MCheck;
            end
          end
        end
      endcase
    end
    m_run = 1;
  endtask

  // ch0: clock pattern (optionally zero or inverted in a window); ch1+: 7-bit counter.
  function automatic logic gen_bit(input int c, input int idx);
    int l;
    logic [OUT_W-1:0] pv;
    logic p;
    l  = idx - off;
    pv = PAT;
    if (c == 0) begin
      if (ch0_zero != 0) return 1'b0;
      p = pv[((l % OUT_W) + OUT_W) % OUT_W];
      if (idx >= cor_lo && idx < cor_hi) p = ~p;
      return p;
    end
    if (l < 0) return 1'b0;
    return 1'(((l / OUT_W) >> (l % OUT_W)) & 1);
  endfunction

  task automatic drive();
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < IN_W; b++) in_data[c*IN_W+b] = gen_bit(c, k * IN_W + b);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drive();
  endtask

  // Per-cycle compare against the model, plus a model-independent ch1 ordering check.
  int   seq_prev;
  bit   seq_have = 0;
  always @(negedge clk) begin
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("out_data", out_data, m_od);
    chk("in_ready", in_ready, m_ready());
    chk("px_ready", px_ready, m_px);
    chk("align_fail", align_fail, m_fail);
    chk("slip_count", slip_count, m_slip);
    chk("lock_loss_count", lock_loss_count, m_loss);
    if (px_ready && out_valid) begin
      if (seq_have) chk("ch1_sequence", out_data[2*OUT_W-1:OUT_W], (seq_prev + 1) % 128);
      seq_prev = int'(out_data[2*OUT_W-1:OUT_W]);
      seq_have = 1;
    end else if (!px_ready) begin
      seq_have = 0;
    end
  end

  initial begin
    int nv, na, cnt, prev_slip;
    bit got;
    off = 0; ch0_zero = 0; cor_lo = -1; cor_hi = -1; m_emitted = 0;
    model_reset();
    drive();
    repeat (3) tick();
    chk("reset_in_ready", in_ready, 0);

    // Aligned stream: lock after exactly LOCK_CNT presented words, no slips.
    rst = 0; in_valid = 1;
    nv = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (px_ready) got = 1;
      else if (out_valid) nv++;
    end
    chk("aligned_lock_reached", got, 1);
    chk("words_before_px_ready", nv, LOCK_CNT);
    chk("aligned_slip_count", slip_count, 0);
    repeat (20) tick();

    // Three corrupted ch0 words keep lock; four lose it, then relock.
    cor_lo = OUT_W * (m_emitted + 8); cor_hi = cor_lo + 3 * OUT_W;
    repeat (40) tick();
    chk("px_ready_after_3_miss", px_ready, 1);
    chk("loss_after_3_miss", lock_loss_count, 0);
    cor_lo = OUT_W * (m_emitted + 8); cor_hi = cor_lo + 4 * OUT_W;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (!px_ready) got = 1;
    end
    chk("px_ready_dropped_after_4", got, 1);
    chk("loss_after_4_miss", lock_loss_count, 1);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (px_ready) got = 1;
    end
    chk("relock", got, 1);
    chk("relock_slip_count", slip_count, 0);

    // Gappy input, then steady-state throughput over 56 cycles.
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3) != 0;
      tick();
    end
    in_valid = 1;
    repeat (20) tick();
    nv = 0; na = 0;
    for (int i = 0; i < 56; i++) begin
      if (in_valid && in_ready) na++;
      if (out_valid) nv++;
      tick();
    end
    chk("tput_out_valid_56", nv, 56);
    chk("tput_accepts_49_pm1", (na >= 48 && na <= 50), 1);
    chk("tput_still_locked", px_ready, 1);

    // Asynchronous reset mid-stream.
    tick();
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_px_ready", px_ready, 0);
    chk("rst_slip_count", slip_count, 0);
    chk("rst_lock_loss_count", lock_loss_count, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) tick();

    // Stream offset by 4 bits: four slips, each followed by SLIP_WAIT ignored words.
    off = 4;
    rst = 0;
    drive();
    nv = 0; got = 0; cnt = 0; prev_slip = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (i < 2 && out_valid) nv++;
      if (slip_count != prev_slip[7:0]) begin
        if (prev_slip > 0) chk("words_between_slips", cnt, SLIP_WAIT + 1);
        cnt = 0;
        prev_slip = int'(slip_count);
      end
      if (out_valid) cnt++;
      if (px_ready) got = 1;
    end
    chk("no_residual_after_reset", nv, 0);
    chk("offset_lock_reached", got, 1);
    chk("offset_slip_count", slip_count, 4);
    repeat (20) tick();

    // ch0 stuck at zero: lose lock, slip until align_fail, keep slipping, then restart.
    ch0_zero = 1;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (align_fail) got = 1;
    end
    chk("align_fail_set", got, 1);
    chk("slip_count_at_fail", slip_count, 2 * OUT_W);
    repeat (30) tick();
    chk("slip_keeps_counting", slip_count > 8'(2 * OUT_W), 1);
    chk("align_fail_sticky", align_fail, 1);
    restart = 1;
    tick();
    restart = 0;
    chk("restart_clears_fail", align_fail, 0);
    chk("restart_clears_slip", slip_count, 0);
    chk("restart_keeps_loss", lock_loss_count, 1);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
